// File: rtl/ppt_seq_defs.sv
// Shared definitions for the pulse-train sequencer: state encoding, table field codes
// and default widths.
package ppt_seq_defs;

    localparam int unsigned DEF_N_SEG = 4;
    localparam int unsigned DEF_PW    = 14;
    localparam int unsigned DEF_CW    = 8;
    localparam int unsigned DEF_GW    = 8;

    localparam logic [1:0] FLD_PERIOD = 2'd0;
    localparam logic [1:0] FLD_WIDTH  = 2'd1;
    localparam logic [1:0] FLD_COUNT  = 2'd2;
    localparam logic [1:0] FLD_GAP    = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StGap,
        StNext
    } seq_state_e;

endpackage

// File: rtl/ppt_seg_table.sv
// Segment descriptor register file: one write port addressed by {segment, field},
// combinational read of a whole segment.
module ppt_seg_table
    import ppt_seq_defs::*;
#(
    parameter int unsigned N_SEG = DEF_N_SEG,
    parameter int unsigned PW    = DEF_PW,
    parameter int unsigned CW    = DEF_CW,
    parameter int unsigned GW    = DEF_GW,
    localparam int unsigned SW   = $clog2(N_SEG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [SW+1:0] cfg_addr,
    input  logic [PW-1:0] cfg_wdata,
    input  logic [SW-1:0] rd_idx,
    output logic [PW-1:0] rd_period,
    output logic [PW-1:0] rd_width,
    output logic [CW-1:0] rd_count,
    output logic [GW-1:0] rd_gap
);

    logic [PW-1:0] period_q [N_SEG];
    logic [PW-1:0] period_d [N_SEG];
    logic [PW-1:0] width_q  [N_SEG];
    logic [PW-1:0] width_d  [N_SEG];
    logic [CW-1:0] count_q  [N_SEG];
    logic [CW-1:0] count_d  [N_SEG];
    logic [GW-1:0] gap_q    [N_SEG];
    logic [GW-1:0] gap_d    [N_SEG];
    logic [SW-1:0] wr_seg;

    assign wr_seg = cfg_addr[SW+1:2];

    // Count and gap fields take the low bits of the write data.
    always_comb begin
        period_d = period_q;
        width_d  = width_q;
        count_d  = count_q;
        gap_d    = gap_q;
        if (cfg_we) begin
            unique case (cfg_addr[1:0])
                FLD_PERIOD: period_d[wr_seg] = cfg_wdata;
                FLD_WIDTH:  width_d[wr_seg]  = cfg_wdata;
                FLD_COUNT:  count_d[wr_seg]  = cfg_wdata[CW-1:0];
                FLD_GAP:    gap_d[wr_seg]    = cfg_wdata[GW-1:0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '{default: '0};
            width_q  <= '{default: '0};
            count_q  <= '{default: '0};
            gap_q    <= '{default: '0};
        end else begin
            period_q <= period_d;
            width_q  <= width_d;
            count_q  <= count_d;
            gap_q    <= gap_d;
        end
    end

    assign rd_period = period_q[rd_idx];
    assign rd_width  = width_q[rd_idx];
    assign rd_count  = count_q[rd_idx];
    assign rd_gap    = gap_q[rd_idx];

endmodule

// File: rtl/ppt_sequencer.sv
// Pulse-train sequencer: walks the segment table, drives the pulse generator/counter
// pair one segment at a time, inserts gaps and repeats the table a set number of passes.
module ppt_sequencer
    import ppt_seq_defs::*;
#(
    parameter int unsigned N_SEG = DEF_N_SEG,
    parameter int unsigned PW    = DEF_PW,
    parameter int unsigned CW    = DEF_CW,
    parameter int unsigned GW    = DEF_GW,
    localparam int unsigned SW   = $clog2(N_SEG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [SW+1:0] cfg_addr,
    input  logic [PW-1:0] cfg_wdata,
    input  logic [SW-1:0] num_seg,
    input  logic [7:0]    loops,
    input  logic          start,
    input  logic          abort,
    input  logic          ppt_done,
    output logic [PW-1:0] ppt_period,
    output logic [PW-1:0] ppt_width,
    output logic [CW-1:0] ppt_count,
    output logic          ppt_run,
    output logic          busy,
    output logic [SW-1:0] seg_idx,
    output logic [7:0]    loop_cnt,
    output logic          seq_done,
    output logic          cfg_err
);

    localparam logic [SW-1:0] SegOne = SW'(1);
    localparam logic [GW-1:0] GapOne = GW'(1);

    seq_state_e    state_q, state_d;
    logic [SW-1:0] seg_idx_q, seg_idx_d;
    logic [7:0]    loop_cnt_q, loop_cnt_d, loop_inc;
    logic [PW-1:0] period_q, period_d, width_q, width_d;
    logic [CW-1:0] count_q, count_d;
    logic [GW-1:0] gap_q, gap_d, gap_cnt_q, gap_cnt_d;
    logic          seq_done_q, seq_done_d, cfg_err_q, cfg_err_d;
    logic [PW-1:0] tbl_period, tbl_width;
    logic [CW-1:0] tbl_count;
    logic [GW-1:0] tbl_gap;
    logic          seg_bad;

    ppt_seg_table #(
        .N_SEG (N_SEG),
        .PW    (PW),
        .CW    (CW),
        .GW    (GW)
    ) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .rd_idx    (seg_idx_q),
        .rd_period (tbl_period),
        .rd_width  (tbl_width),
        .rd_count  (tbl_count),
        .rd_gap    (tbl_gap)
    );

    assign loop_inc = loop_cnt_q + 8'd1;
    assign seg_bad  = (tbl_period == '0) || (tbl_width >= tbl_period);

    always_comb begin
        state_d    = state_q;
        seg_idx_d  = seg_idx_q;
        loop_cnt_d = loop_cnt_q;
        period_d   = period_q;
        width_d    = width_q;
        count_d    = count_q;
        gap_d      = gap_q;
        gap_cnt_d  = gap_cnt_q;
        seq_done_d = 1'b0;
        cfg_err_d  = cfg_err_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        seg_idx_d  = '0;
                        loop_cnt_d = '0;
                        cfg_err_d  = 1'b0;
                        state_d    = StLoad;
                    end
                end
                StLoad: begin
                    period_d = tbl_period;
                    width_d  = tbl_width;
                    count_d  = tbl_count;
                    gap_d    = tbl_gap;
                    if (seg_bad) begin
                        cfg_err_d = 1'b1;
                        state_d   = StIdle;
                    end else if (tbl_count == '0) begin
                        state_d = StNext;
                    end else if (!ppt_done) begin
                        // Holding here while done is high lets the counter see run low.
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (ppt_done) begin
                        if (gap_q != '0) begin
                            gap_cnt_d = gap_q - GapOne;
                            state_d   = StGap;
                        end else begin
                            state_d = StNext;
                        end
                    end
                end
                StGap: begin
                    if (gap_cnt_q == '0) begin
                        state_d = StNext;
                    end else begin
                        gap_cnt_d = gap_cnt_q - GapOne;
                    end
                end
                StNext: begin
                    if (seg_idx_q < num_seg) begin
                        seg_idx_d = seg_idx_q + SegOne;
                        state_d   = StLoad;
                    end else begin
                        loop_cnt_d = loop_inc;
                        if ((loops != 8'd0) && (loop_inc == loops)) begin
                            seq_done_d = 1'b1;
                            state_d    = StIdle;
                        end else begin
                            seg_idx_d = '0;
                            state_d   = StLoad;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            seg_idx_q  <= '0;
            loop_cnt_q <= '0;
            period_q   <= '0;
            width_q    <= '0;
            count_q    <= '0;
            gap_q      <= '0;
            gap_cnt_q  <= '0;
            seq_done_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            seg_idx_q  <= seg_idx_d;
            loop_cnt_q <= loop_cnt_d;
            period_q   <= period_d;
            width_q    <= width_d;
            count_q    <= count_d;
            gap_q      <= gap_d;
            gap_cnt_q  <= gap_cnt_d;
            seq_done_q <= seq_done_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign ppt_period = period_q;
    assign ppt_width  = width_q;
    assign ppt_count  = count_q;
    assign ppt_run    = (state_q == StRun);
    assign busy       = (state_q != StIdle);
    assign seg_idx    = seg_idx_q;
    assign loop_cnt   = loop_cnt_q;
    assign seq_done   = seq_done_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_ppt_sequencer.sv
// Directed bench for ppt_sequencer; a simple pulse_counter model answers ppt_done after
// ppt_count run-high cycles and a monitor logs every run burst.
module tb_ppt_sequencer;

    localparam int unsigned PW = 14;
    localparam int unsigned CW = 8;
    localparam int unsigned SW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [SW+1:0] cfg_addr = '0;
    logic [PW-1:0] cfg_wdata = '0;
    logic [SW-1:0] num_seg = '0;
    logic [7:0]    loops = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          ppt_done;
    logic [PW-1:0] ppt_period, ppt_width;
    logic [CW-1:0] ppt_count;
    logic          ppt_run, busy, seq_done, cfg_err;
    logic [SW-1:0] seg_idx;
    logic [7:0]    loop_cnt;

    ppt_sequencer u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .num_seg    (num_seg),
        .loops      (loops),
        .start      (start),
        .abort      (abort),
        .ppt_done   (ppt_done),
        .ppt_period (ppt_period),
        .ppt_width  (ppt_width),
        .ppt_count  (ppt_count),
        .ppt_run    (ppt_run),
        .busy       (busy),
        .seg_idx    (seg_idx),
        .loop_cnt   (loop_cnt),
        .seq_done   (seq_done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int period;
        int count;
        int high;
        int low;
    } rec_t;

    rec_t recs[$];
    rec_t cur;
    int   seg_log[$];
    int   low_cnt = 0;
    int   pcnt = 0;
    int   seq_done_cnt = 0;
    bit   run_prev = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Counter model plus burst logger; runs 1 time unit after each rising edge.
    initial begin
        ppt_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                ppt_done = 1'b0;
                pcnt     = 0;
                run_prev = 1'b0;
            end else begin
                if (seq_done) seq_done_cnt++;
                if (busy && (seg_log.size() == 0 || seg_log[$] != int'(seg_idx)))
                    seg_log.push_back(int'(seg_idx));
                if (ppt_run) begin
                    if (!run_prev) begin
                        cur.period = int'(ppt_period);
                        cur.count  = int'(ppt_count);
                        cur.high   = 0;
                        cur.low    = low_cnt;
                        low_cnt    = 0;
                    end
                    cur.high++;
                    pcnt++;
                    if (pcnt >= int'(ppt_count)) begin
                        ppt_done = 1'b1;
                        pcnt     = 0;
                    end else begin
                        ppt_done = 1'b0;
                    end
                end else begin
                    if (run_prev) recs.push_back(cur);
                    ppt_done = 1'b0;
                    pcnt     = 0;
                    if (busy) low_cnt++;
                end
                run_prev = ppt_run;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(input int seg, input int fld, input int data);
        cfg_we    = 1'b1;
        cfg_addr  = 4'(seg * 4 + fld);
        cfg_wdata = 14'(data);
        tick(1);
        cfg_we    = 1'b0;
    endtask

    task automatic wr_seg(input int s, input int p, input int w, input int c, input int g);
        wr(s, 0, p);
        wr(s, 1, w);
        wr(s, 2, c);
        wr(s, 3, g);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic clear_mon();
        recs.delete();
        seg_log.delete();
        low_cnt      = 0;
        seq_done_cnt = 0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        check_val(tag, busy, 0);
    endtask

    int e_per[4] = '{8, 6, 8, 6};
    int e_cnt[4] = '{3, 2, 3, 2};
    int e_low[4] = '{1, 6, 2, 6};

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        check_val("rst_busy", busy, 0);
        check_val("rst_run", ppt_run, 0);
        check_val("rst_outs", {ppt_period, ppt_width, ppt_count, seg_idx, loop_cnt,
                               seq_done, cfg_err}, 0);

        // Single segment, one pass, with start->run latency.
        wr_seg(0, 10, 3, 5, 0);
        num_seg = 2'd0;
        loops   = 8'd1;
        clear_mon();
        pulse_start();
        check_val("t1_lat_busy", busy, 1);
        check_val("t1_lat_run0", ppt_run, 0);
        tick(1);
        check_val("t1_lat_run1", ppt_run, 1);
        wait_idle("t1_idle", 100);
        check_val("t1_seq_done", seq_done, 1);
        check_val("t1_loop_cnt", loop_cnt, 1);
        tick(1);
        check_val("t1_done_pulse", seq_done, 0);
        check_val("t1_nrec", recs.size(), 1);
        check_val("t1_high", recs[0].high, 5);
        check_val("t1_count", recs[0].count, 5);
        check_val("t1_per_wid", {ppt_period, ppt_width}, {14'd10, 14'd3});
        check_val("t1_ndone", seq_done_cnt, 1);

        // Two segments with gap, two passes; low time = gap + NEXT + LOAD.
        wr_seg(0, 8, 2, 3, 4);
        wr_seg(1, 6, 1, 2, 0);
        num_seg = 2'd1;
        loops   = 8'd2;
        clear_mon();
        pulse_start();
        wait_idle("t2_idle", 200);
        check_val("t2_seq_done", seq_done, 1);
        check_val("t2_loop_cnt", loop_cnt, 2);
        tick(1);
        check_val("t2_nrec", recs.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("t2_per%0d", i), recs[i].period, e_per[i]);
            check_val($sformatf("t2_high%0d", i), recs[i].high, e_cnt[i]);
            check_val($sformatf("t2_low%0d", i), recs[i].low, e_low[i]);
        end
        check_val("t2_ndone", seq_done_cnt, 1);

        // Invalid seg1 (width == period): error, no seq_done; next start clears.
        wr(1, 0, 7);
        wr(1, 1, 7);
        loops = 8'd1;
        clear_mon();
        pulse_start();
        wait_idle("t3_idle", 200);
        check_val("t3_cfg_err", cfg_err, 1);
        check_val("t3_seg_idx", seg_idx, 1);
        tick(1);
        check_val("t3_ndone", seq_done_cnt, 0);
        check_val("t3_nrec", recs.size(), 1);
        wr(1, 1, 1);
        pulse_start();
        check_val("t3_err_clr", cfg_err, 0);
        wait_idle("t3_idle2", 200);
        tick(1);
        check_val("t3_ndone2", seq_done_cnt, 1);

        // Skipped seg1 (count == 0).
        wr_seg(0, 8, 2, 3, 0);
        wr_seg(1, 6, 1, 0, 0);
        wr_seg(2, 5, 2, 1, 0);
        num_seg = 2'd2;
        clear_mon();
        pulse_start();
        wait_idle("t4_idle", 200);
        tick(1);
        check_val("t4_nrec", recs.size(), 2);
        check_val("t4_per1", recs[1].period, 5);
        check_val("t4_low1", recs[1].low, 4);
        check_val("t4_nlog", seg_log.size(), 3);
        check_val("t4_log12", {seg_log[1][1:0], seg_log[2][1:0]}, {2'd1, 2'd2});
        check_val("t4_ndone", seq_done_cnt, 1);

        // Table edit during RUN only affects the next LOAD.
        wr_seg(0, 10, 3, 20, 0);
        num_seg = 2'd0;
        loops   = 8'd2;
        clear_mon();
        pulse_start();
        tick(3);
        wr(0, 2, 4);
        wait_idle("t8_idle", 300);
        tick(1);
        check_val("t8_nrec", recs.size(), 2);
        check_val("t8_high0", recs[0].high, 20);
        check_val("t8_count1", recs[1].count, 4);
        check_val("t8_high1", recs[1].high, 4);
        check_val("t8_loop_cnt", loop_cnt, 2);

        // Abort mid-RUN, then abort together with start.
        wr_seg(0, 10, 3, 200, 0);
        loops = 8'd1;
        clear_mon();
        pulse_start();
        tick(5);
        check_val("t5_running", ppt_run, 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check_val("t5_run_off", ppt_run, 0);
        check_val("t5_busy_off", busy, 0);
        start = 1'b1;
        abort = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        check_val("t5_abort_wins", busy, 0);
        tick(1);
        check_val("t5_still_idle", {busy, ppt_run}, 0);
        check_val("t5_ndone", seq_done_cnt, 0);

        // Infinite loop: loop_cnt wraps 255 -> 0 without seq_done.
        wr_seg(0, 4, 1, 1, 0);
        loops = 8'd0;
        clear_mon();
        pulse_start();
        n = 0;
        while (loop_cnt != 8'd255 && n < 2000) begin
            tick(1);
            n++;
        end
        check_val("t6_reach255", loop_cnt, 255);
        n = 0;
        while (loop_cnt != 8'd0 && n < 10) begin
            tick(1);
            n++;
        end
        check_val("t6_wrap", loop_cnt, 0);
        check_val("t6_busy", busy, 1);
        check_val("t6_ndone", seq_done_cnt, 0);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check_val("t6_abort", busy, 0);

        // Asynchronous reset during GAP, then the table must read back as zero.
        wr_seg(0, 8, 2, 3, 50);
        loops = 8'd1;
        clear_mon();
        pulse_start();
        tick(8);
        check_val("t7_in_gap", {busy, ppt_run}, 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t7_busy", busy, 0);
        check_val("t7_period", ppt_period, 0);
        check_val("t7_outs", {ppt_period, ppt_width, ppt_count, ppt_run, seg_idx, loop_cnt,
                              seq_done, cfg_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        num_seg = 2'd0;
        clear_mon();
        pulse_start();
        wait_idle("t7_tbl_idle", 10);
        check_val("t7_tbl_err", cfg_err, 1);
        tick(1);
        check_val("t7_tbl_ndone", seq_done_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
